// File: rtl/axis_keep_packer.sv
// axis_keep_packer: drops null tkeep lanes and repacks dense lane-0 beats.
// Define KEEP_PACKER_STATS_EN to add the stat_words/stat_pkts counters.
module axis_keep_packer #(
  parameter int Y_BITS = 32,
  parameter int LANES  = 8
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [LANES*Y_BITS-1:0] s_axis_tdata,
  input  logic [LANES-1:0]        s_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [LANES*Y_BITS-1:0] m_axis_tdata,
  output logic [LANES-1:0]        m_axis_tkeep
`ifdef KEEP_PACKER_STATS_EN
  ,
  output logic [31:0]             stat_words,
  output logic [31:0]             stat_pkts
`endif
);

  localparam int DEPTH = 2*LANES-1;
  localparam int CW    = $clog2(2*LANES);
  localparam int PW    = $clog2(LANES+1);

  localparam logic [CW-1:0] FULL = CW'(LANES);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  logic [0:0]        state;
  logic [0:0]        state_n;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_n;
  logic [CW-1:0]     base;
  logic [Y_BITS-1:0] lane_q [DEPTH];
  logic [Y_BITS-1:0] lane_n [DEPTH];
  logic [Y_BITS-1:0] shift  [DEPTH];
  logic [Y_BITS-1:0] comp   [LANES];
  logic [PW-1:0]     rank   [LANES];
  logic [PW-1:0]     sum;
  logic [PW-1:0]     pcnt;
  logic              pop;
  logic              acc;

  assign pop = m_axis_tvalid && m_axis_tready;
  assign acc = s_axis_tvalid && s_axis_tready;

  assign s_axis_tready = (state == RUN) &&
                         ((cnt < FULL) || m_axis_tready);
  assign m_axis_tvalid = (state == FLUSH) || (cnt >= FULL);
  assign m_axis_tlast  = (state == FLUSH) && (cnt <= FULL);

  // Output beat: low lanes of the buffer, keep derived from fill count.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      m_axis_tdata[i*Y_BITS +: Y_BITS] = lane_q[i];
      m_axis_tkeep[i] = (state == FLUSH) ? (CW'(i) < cnt)
                                         : (cnt >= FULL);
    end
  end

  // Rank of each kept lane among the kept lanes below it.
  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      rank[i] = sum;
      sum = sum + PW'(s_axis_tkeep[i]);
    end
    pcnt = sum;
  end

  // Compacted input words, ascending lane order.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      comp[j] = '0;
      for (int i = 0; i < LANES; i++) begin
        if (s_axis_tkeep[i] && rank[i] == PW'(j))
          comp[j] = s_axis_tdata[i*Y_BITS +: Y_BITS];
      end
    end
  end

  // Pop first (shift down by one beat), then append at the new fill.
  always_comb begin
    if (!pop)
      base = cnt;
    else if (cnt > FULL)
      base = cnt - FULL;
    else
      base = '0;
    cnt_n = base + (acc ? CW'(pcnt) : '0);
    for (int p = 0; p < DEPTH-LANES; p++)
      shift[p] = pop ? lane_q[p+LANES] : lane_q[p];
    for (int p = DEPTH-LANES; p < DEPTH; p++)
      shift[p] = pop ? '0 : lane_q[p];
    for (int p = 0; p < DEPTH; p++) begin
      lane_n[p] = shift[p];
      for (int j = 0; j < LANES; j++) begin
        if (acc && PW'(j) < pcnt &&
            ({1'b0, base} + (CW+1)'(j)) == (CW+1)'(p))
          lane_n[p] = comp[j];
      end
    end
  end

  // RUN accepts until a tlast beat; FLUSH drains, ending in a tlast beat.
  always_comb begin
    state_n = state;
    case (state)
      RUN:     if (acc && s_axis_tlast) state_n = FLUSH;
      FLUSH:   if (pop && cnt <= FULL) state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  // State, fill count and lane buffer registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= RUN;
      cnt   <= '0;
      for (int p = 0; p < DEPTH; p++)
        lane_q[p] <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      for (int p = 0; p < DEPTH; p++)
        lane_q[p] <= lane_n[p];
    end
  end

`ifdef KEEP_PACKER_STATS_EN
  // Accepted-word and emitted-packet counters, wrapping at 2^32.
  always_ff @(posedge aclk) begin
    if (areset) begin
      stat_words <= '0;
      stat_pkts  <= '0;
    end else begin
      if (acc)
        stat_words <= stat_words + 32'(pcnt);
      if (pop && m_axis_tlast)
        stat_pkts <= stat_pkts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_keep_packer.sv
// tb_axis_keep_packer: directed table, reset abort and random stress
// for axis_keep_packer with LANES=4, Y_BITS=8.
module tb_axis_keep_packer;

  localparam int YB = 8;
  localparam int LN = 4;

  logic        clk = 1'b0;
  logic        areset;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
`ifdef KEEP_PACKER_STATS_EN
  logic [31:0] stat_words;
  logic [31:0] stat_pkts;
`endif

  axis_keep_packer #(.Y_BITS(YB), .LANES(LN)) dut (
    .aclk          (clk),
    .areset        (areset),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .s_axis_tlast  (s_last),
    .s_axis_tdata  (s_data),
    .s_axis_tkeep  (s_keep),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .m_axis_tlast  (m_last),
    .m_axis_tdata  (m_data),
    .m_axis_tkeep  (m_keep)
`ifdef KEEP_PACKER_STATS_EN
    ,
    .stat_words    (stat_words),
    .stat_pkts     (stat_pkts)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  function automatic logic [31:0] kmask(input logic [3:0] k);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = {8{k[i]}};
    return r;
  endfunction

  function automatic int popc(input logic [3:0] k);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(k[i]);
    return n;
  endfunction

  function automatic logic [3:0] lowk(input int n);
    logic [3:0] r = '0;
    for (int i = 0; i < 4; i++) if (i < n) r[i] = 1'b1;
    return r;
  endfunction

  typedef struct {
    logic        sv;
    logic        sl;
    logic [3:0]  sk;
    logic [31:0] sd;
    logic        mr;
    logic        ev;
    logic        el;
    logic [3:0]  ek;
    logic [31:0] ed;
    logic        esr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic sv, input logic sl, input logic [3:0] sk,
                     input logic [31:0] sd, input logic mr,
                     input logic ev, input logic el, input logic [3:0] ek,
                     input logic [31:0] ed, input logic esr);
    vq.push_back('{sv, sl, sk, sd, mr, ev, el, ek, ed, esr});
  endtask

  logic [7:0]  exp_words[$];
  int          pkt_len[$];
  int          in_cnt;
  int          out_cnt;
  int          pk_gen;
  int          pk_out;
  int          beats_left;
  int          cyc;
  int          n;
  bit          has_beat;
  bit          took;
  bit          stall;
  logic        sv_last;
  logic [3:0]  sv_keep;
  logic [31:0] sv_data;

  initial begin
    areset  = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_keep  = '0;
    s_data  = '0;
    m_ready = 1'b1;

    // dense
    add(1,0,4'hF,32'h03020100,1, 0,0,4'h0,32'h0,1);
    add(1,0,4'hF,32'h07060504,1, 1,0,4'hF,32'h03020100,1);
    add(1,1,4'hF,32'h0B0A0908,1, 1,0,4'hF,32'h07060504,1);
    add(0,0,4'h0,32'h0,1,        1,1,4'hF,32'h0B0A0908,0);
    add(0,0,4'h0,32'h0,1,        0,0,4'h0,32'h0,1);
    // sparse
    add(1,0,4'h5,32'hEEA2EEA1,1, 0,0,4'h0,32'h0,1);
    add(1,0,4'hA,32'hA4EEA3EE,1, 0,0,4'h0,32'h0,1);
    add(1,1,4'h3,32'hEEEEA6A5,1, 1,0,4'hF,32'hA4A3A2A1,1);
    add(0,0,4'h0,32'h0,1,        1,1,4'h3,32'h0000A6A5,0);
    add(0,0,4'h0,32'h0,1,        0,0,4'h0,32'h0,1);
    // overflow flush
    add(1,0,4'h7,32'hEE030201,1, 0,0,4'h0,32'h0,1);
    add(1,1,4'hF,32'h07060504,1, 0,0,4'h0,32'h0,1);
    add(0,0,4'h0,32'h0,1,        1,0,4'hF,32'h04030201,0);
    add(0,0,4'h0,32'h0,1,        1,1,4'h7,32'h00070605,0);
    add(0,0,4'h0,32'h0,1,        0,0,4'h0,32'h0,1);
    // empty packet
    add(1,1,4'h0,32'h0,1,        0,0,4'h0,32'h0,1);
    add(0,0,4'h0,32'h0,1,        1,1,4'h0,32'h0,0);
    add(0,0,4'h0,32'h0,1,        0,0,4'h0,32'h0,1);
    // backpressure
    add(1,0,4'hF,32'h13121110,0, 0,0,4'h0,32'h0,1);
    add(1,1,4'hF,32'h17161514,0, 1,0,4'hF,32'h13121110,0);
    add(1,1,4'hF,32'h17161514,1, 1,0,4'hF,32'h13121110,1);
    add(0,0,4'h0,32'h0,0,        1,1,4'hF,32'h17161514,0);
    add(0,0,4'h0,32'h0,1,        1,1,4'hF,32'h17161514,0);
    add(0,0,4'h0,32'h0,1,        0,0,4'h0,32'h0,1);

    repeat (2) @(negedge clk);
    areset = 1'b0;
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_last",  m_last,  0);
    chk("rst_keep",  m_keep,  0);
    chk("rst_data",  m_data,  0);
    chk("rst_ready", s_ready, 1);

    foreach (vq[i]) begin
      @(negedge clk);
      s_valid = vq[i].sv;
      s_last  = vq[i].sl;
      s_keep  = vq[i].sk;
      s_data  = vq[i].sd;
      m_ready = vq[i].mr;
      #1;
      chk($sformatf("v%0d_valid", i), m_valid, vq[i].ev);
      chk($sformatf("v%0d_sready", i), s_ready, vq[i].esr);
      chk($sformatf("v%0d_last", i), m_last, vq[i].el);
      if (vq[i].ev) begin
        chk($sformatf("v%0d_keep", i), m_keep, vq[i].ek);
        chk($sformatf("v%0d_data", i),
            m_data & kmask(vq[i].ek), vq[i].ed);
      end
    end

    // reset with five words buffered
    @(negedge clk);
    s_valid = 1; s_last = 0; s_keep = 4'h7; s_data = 32'hEE030201;
    m_ready = 0;
    #1 chk("ra_sready0", s_ready, 1);
    @(negedge clk);
    s_keep = 4'h3; s_data = 32'hEEEE0504;
    #1 chk("ra_sready1", s_ready, 1);
    @(negedge clk);
    s_valid = 0;
    #1;
    chk("ra_valid_c5", m_valid, 1);
    chk("ra_sready_c5", s_ready, 0);
    areset = 1;
    @(negedge clk);
    areset = 0;
    #1;
    chk("ra_valid", m_valid, 0);
    chk("ra_sready", s_ready, 1);
    chk("ra_keep", m_keep, 0);
    s_valid = 1; s_last = 1; s_keep = 4'h3; s_data = 32'hEEEE4241;
    m_ready = 1;
    @(negedge clk);
    s_valid = 0; s_last = 0;
    #1;
    chk("ra_pkt_valid", m_valid, 1);
    chk("ra_pkt_last", m_last, 1);
    chk("ra_pkt_keep", m_keep, 4'h3);
    chk("ra_pkt_data", m_data & kmask(4'h3), 32'h00004241);
    @(negedge clk);
    #1 chk("ra_idle", m_valid, 0);

    // random stress against a reference compaction
    in_cnt = 0; out_cnt = 0; pk_gen = 0; pk_out = 0;
    beats_left = 0; cyc = 0; has_beat = 0; took = 0; stall = 0;
    s_valid = 0;
    while (pk_out < 200 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (took) begin
        has_beat = 0;
        s_valid  = 0;
        took     = 0;
      end
      if (!has_beat && pk_gen < 200) begin
        if (beats_left == 0) beats_left = $urandom_range(1, 4);
        s_keep = 4'($urandom_range(0, 15));
        s_data = $urandom;
        beats_left--;
        s_last = (beats_left == 0);
        if (s_last) pk_gen++;
        has_beat = 1;
      end
      if (has_beat && !s_valid) s_valid = 1'($urandom_range(0, 1));
      m_ready = 1'($urandom_range(0, 1));
      #1;
      if (stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_last", m_last, sv_last);
        chk("stall_keep", m_keep, sv_keep);
        chk("stall_data", m_data & kmask(sv_keep),
            sv_data & kmask(sv_keep));
      end
      if (s_valid && s_ready) begin
        took = 1;
        for (int i = 0; i < 4; i++)
          if (s_keep[i]) begin
            exp_words.push_back(s_data[i*8 +: 8]);
            in_cnt++;
          end
        if (s_last) begin
          pkt_len.push_back(in_cnt);
          in_cnt = 0;
        end
      end
      if (m_valid && m_ready) begin
        n = popc(m_keep);
        chk("rnd_keep_contig", m_keep, lowk(n));
        for (int i = 0; i < 4; i++)
          if (i < n) begin
            if (exp_words.size() == 0) fail_now("rnd_extra_word");
            else chk("rnd_data", m_data[i*8 +: 8], exp_words.pop_front());
          end
        out_cnt += n;
        if (!m_last) begin
          chk("rnd_full_keep", m_keep, 4'hF);
        end else begin
          if (pkt_len.size() == 0) fail_now("rnd_extra_last");
          else chk("rnd_pkt_len", out_cnt, pkt_len.pop_front());
          out_cnt = 0;
          pk_out++;
        end
      end
      stall   = m_valid && !m_ready;
      sv_last = m_last;
      sv_keep = m_keep;
      sv_data = m_data;
    end
    if (pk_out < 200) fail_now("rnd_timeout");
    chk("rnd_pkts", pk_out, 200);
    chk("rnd_words_left", exp_words.size(), 0);
    chk("rnd_lens_left", pkt_len.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
